// File: rtl/mat_fifo_loader.sv
// Matrix FIFO loader: fetches the B vector word and NUM_ROWS matrix-A row words
// from memory (one read outstanding at a time). Each 64-bit word is unpacked
// MSB byte first onto a shared write bus feeding the B FIFO or the target A FIFO.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// REQ    | read request for word w held on the bus until accepted
// WAIT   | request accepted, waiting for readdatavalid
// UNPACK | writing the 8 held bytes to the target FIFO, stalling on full
// DONE   | all words written; waits for start to drop before re-arming
module mat_fifo_loader #(
    parameter int          DATA_WIDTH = 8,
    parameter int          NUM_ROWS   = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [31:0]           address,
    output logic                  read,
    input  logic [63:0]           readdata,
    input  logic                  readdatavalid,
    input  logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [NUM_ROWS-1:0]   wrreq_A,
    output logic                  wrreq_B,
    input  logic [NUM_ROWS-1:0]   wrfull_A,
    input  logic                  wrfull_B,
    output logic                  busy,
    output logic                  done
);

    localparam int            WW     = $clog2(NUM_ROWS + 1);
    localparam logic [WW-1:0] LAST_W = WW'(NUM_ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UNPACK,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] w_idx;
    logic [2:0]    b_idx;
    logic [63:0]   hold;
    logic [7:0]    cur_byte;
    logic          tgt_full;
    logic          wr_fire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word index, byte index and holding register; readdatavalid only matters in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_idx <= '0;
            b_idx <= '0;
            hold  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_idx <= '0;
                    end
                end
                S_WAIT: begin
                    if (readdatavalid) begin
                        hold  <= readdata;
                        b_idx <= '0;
                    end
                end
                S_UNPACK: begin
                    if (wr_fire) begin
                        b_idx <= b_idx + 3'd1;
                        if (b_idx == 3'd7 && w_idx != LAST_W) begin
                            w_idx <= w_idx + WW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic, memory request, and FIFO strobes (only the target FIFO, only when not full)
    always_comb begin
        state_nxt = state;
        address   = '0;
        read      = 1'b0;
        wr_data   = '0;
        wrreq_A   = '0;
        wrreq_B   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_fire   = 1'b0;
        cur_byte  = hold[{~b_idx, 3'b000} +: 8];
        tgt_full  = wrfull_B;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (w_idx == WW'(i + 1)) begin
                tgt_full = wrfull_A[i];
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                read    = 1'b1;
                address = BASE_ADDR + 32'(w_idx);
                if (!waitrequest) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (readdatavalid) begin
                    state_nxt = S_UNPACK;
                end
            end
            S_UNPACK: begin
                busy    = 1'b1;
                wr_data = DATA_WIDTH'(cur_byte);
                if (!tgt_full) begin
                    wr_fire = 1'b1;
                    if (w_idx == '0) begin
                        wrreq_B = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_ROWS; i++) begin
                            wrreq_A[i] = (w_idx == WW'(i + 1));
                        end
                    end
                    if (b_idx == 3'd7) begin
                        state_nxt = (w_idx == LAST_W) ? S_DONE : S_REQ;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
